// File: rtl/dmem_responder_if.sv
// +---------------------------------------------------------------------------+
// | dmem_responder_if : request/response bus between a core and dmem_responder|
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// +---------------------------------------------------------------------------+
// | dmem_responder : single-outstanding data-memory responder, fixed latency  |
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus,
  output logic [31:0]      dmem [DEPTH-1:0]
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = 3;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [31:0]     mem_q [DEPTH-1:0];

  logic            accept;
  logic            addr_bad;
  logic            store_commit;
  logic [IW-1:0]   widx;
  logic [31:0]     load_word;
  logic [31:0]     merge_word;

  // req_ready_q doubles as the IDLE flag so nothing is taken while it reads 0
  assign accept       = req_ready_q && bus.req_valid;
  assign addr_bad     = (bus.req_addr[1:0] != 2'b00) ||
                        ({2'b00, bus.req_addr[31:2]} >= DEPTH_W);
  assign widx         = bus.req_addr[IW+1:2];
  assign load_word    = mem_q[widx];
  assign store_commit = accept && bus.req_we && !addr_bad;

  always_comb begin
    merge_word = load_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.req_be[b]) merge_word[8*b +: 8] = bus.req_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Response is captured at acceptance so the load sees pre-edge memory
          rsp_err_d   = addr_bad;
          rsp_rdata_d = (addr_bad || bus.req_we) ? 32'h0 : load_word;
          if (LATENCY == 1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d     = RESP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge clk) begin
      if (!reset) begin
        mem_q[w] <= 32'h0;
      end else if (store_commit && (widx == IW'(w))) begin
        mem_q[w] <= merge_word;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dmem          = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +---------------------------------------------------------------------------+
// | tb_dmem_responder : directed/table bench over LATENCY = 1, 3 and 4         |
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n;
  logic [2:0]       req_valid, req_we, rsp_ready;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [2:0][3:0]  req_be;
  logic [2:0]       req_ready, rsp_valid, rsp_err;
  logic [2:0][31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if bus ();
    logic [31:0] dm [2047:0];

    assign bus.req_valid = req_valid[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.req_be    = req_be[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_err[g]    = bus.rsp_err;
    assign rsp_rdata[g]  = bus.rsp_rdata;

    dmem_responder #(
      .DEPTH   (2048),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk   (clk),
      .reset (rst_n[g]),
      .bus   (bus.slave),
      .dmem  (dm)
    );
  end

  typedef struct {
    int          k;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction; while busy, a conflicting store to 0x10 is held on the bus
  task automatic xact(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int dly, input logic [31:0] exp_rdata,
                      input bit exp_err, input int exp_lat);
    int n;
    int lat;
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
    req_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_before_accept", 32'(req_ready[k]), 32'd1);
    @(posedge clk); #1;
    req_we[k] = 1'b1; req_addr[k] = 32'h10; req_wdata[k] = 32'h0; req_be[k] = 4'hF;
    lat = 1;
    while (rsp_valid[k] !== 1'b1 && lat < 20) begin
      chk("req_ready_in_wait", 32'(req_ready[k]), 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_rdata", rsp_rdata[k], exp_rdata);
    chk("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
    chk("req_ready_in_resp", 32'(req_ready[k]), 32'd0);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata[k], exp_rdata);
      chk("hold_rsp_err", 32'(rsp_err[k]), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid[k]), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ref_mem [16];
    int          nz;
    int          n;
    bit          seen;

    tbl[0]  = '{0, 1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 0, 32'h0,        1'b0, 1};
    tbl[1]  = '{0, 1'b0, 32'h10,   32'h0,        4'b1111, 1, 32'hDEADBEEF, 1'b0, 1};
    tbl[2]  = '{0, 1'b1, 32'h10,   32'h11223344, 4'b0101, 0, 32'h0,        1'b0, 1};
    tbl[3]  = '{0, 1'b0, 32'h10,   32'h0,        4'b0000, 2, 32'hDE22BE44, 1'b0, 1};
    tbl[4]  = '{0, 1'b0, 32'h13,   32'h0,        4'b1111, 1, 32'h0,        1'b1, 1};
    tbl[5]  = '{0, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'b1111, 0, 32'h0,        1'b1, 1};
    tbl[6]  = '{0, 1'b0, 32'h0,    32'h0,        4'b1111, 0, 32'h0,        1'b0, 1};
    tbl[7]  = '{0, 1'b0, 32'h1FFC, 32'h0,        4'b1111, 0, 32'h0,        1'b0, 1};
    tbl[8]  = '{0, 1'b1, 32'h1FFC, 32'hCAFEF00D, 4'b0000, 0, 32'h0,        1'b0, 1};
    tbl[9]  = '{0, 1'b0, 32'h1FFC, 32'h0,        4'b0000, 0, 32'h0,        1'b0, 1};
    tbl[10] = '{0, 1'b1, 32'h1FFC, 32'hCAFEF00D, 4'b1000, 0, 32'h0,        1'b0, 1};
    tbl[11] = '{0, 1'b0, 32'h1FFC, 32'h0,        4'b0000, 0, 32'hCA000000, 1'b0, 1};
    tbl[12] = '{0, 1'b0, 32'h2,    32'h0,        4'b1111, 0, 32'h0,        1'b1, 1};
    tbl[13] = '{1, 1'b1, 32'h20,   32'h12345678, 4'b1111, 0, 32'h0,        1'b0, 3};
    tbl[14] = '{1, 1'b0, 32'h20,   32'h0,        4'b1111, 5, 32'h12345678, 1'b0, 3};
    tbl[15] = '{1, 1'b1, 32'h21,   32'hFFFFFFFF, 4'b1111, 0, 32'h0,        1'b1, 3};
    tbl[16] = '{2, 1'b0, 32'h20,   32'h0,        4'b1111, 0, 32'h0,        1'b0, 4};

    rst_n = '0; req_valid = '0; req_we = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset_rsp_err",   32'(rsp_err[k]),   32'd0);
      chk("reset_rsp_rdata", rsp_rdata[k],      32'd0);
    end
    rst_n = '1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("release_req_ready", 32'(req_ready[k]), 32'd1);

    for (int i = 0; i < 17; i++) begin
      xact(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].dly,
           tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
      if (i == 0) chk("dmem4_after_store", g_dut[0].dm[4], 32'hDEADBEEF);
      if (i == 2) chk("dmem4_after_merge", g_dut[0].dm[4], 32'hDE22BE44);
    end
    chk("dmem0_untouched",  g_dut[0].dm[0],    32'h0);
    chk("dmem2047_byte3",   g_dut[0].dm[2047], 32'hCA000000);
    chk("dmem4_final",      g_dut[0].dm[4],    32'hDE22BE44);
    chk("inst1_dmem8",      g_dut[1].dm[8],    32'h12345678);

    // Reset aborting an in-flight LATENCY=4 load after a committed store
    xact(2, 1'b1, 32'h40, 32'hAABBCCDD, 4'b1111, 0, 32'h0, 1'b0, 4);
    chk("inst2_dmem16", g_dut[2].dm[16], 32'hAABBCCDD);
    req_we[2] = 1'b0; req_addr[2] = 32'h40; req_be[2] = 4'hF; req_valid[2] = 1'b1;
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen = seen | rsp_valid[2]; end
    rst_n[2] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid[2];
      chk("abort_req_ready_low", 32'(req_ready[2]), 32'd0);
    end
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready_high", 32'(req_ready[2]), 32'd1);
    chk("abort_rsp_rdata", rsp_rdata[2], 32'h0);
    repeat (8) begin @(posedge clk); #1; seen = seen | rsp_valid[2]; end
    chk("abort_no_rsp_valid", 32'(seen), 32'd0);
    nz = 0;
    for (int w = 0; w < 2048; w++) if (g_dut[2].dm[w] != 32'h0) nz++;
    chk("abort_dmem_cleared", 32'(nz), 32'd0);
    xact(2, 1'b0, 32'h40, 32'h0, 4'b1111, 0, 32'h0, 1'b0, 4);

    // Random traffic on LATENCY=1 against a reference memory
    rst_n[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 16; w++) ref_mem[w] = 32'h0;
    for (int t = 0; t < 100; t++) begin
      int          idx;
      bit          we;
      logic [31:0] wd;
      logic [3:0]  be;
      idx = $urandom_range(0, 15);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      be  = 4'($urandom_range(0, 15));
      xact(0, we, 32'(idx) << 2, wd, be, $urandom_range(0, 3),
           we ? 32'h0 : ref_mem[idx], 1'b0, 1);
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        chk("rand_dmem", g_dut[0].dm[idx], ref_mem[idx]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
